wb_port_scheduler: RTL and testbench

- Schedules the single register-file write port between two writeback sources.
- Sources: ALU results, which are buffered in a FIFO, and memory load returns, which have priority.
- Drives the select line (MemtoReg), the two data inputs (ReadData, ALUresult), WriteReg and RegWrite of the writeback mux and register file.
- Includes an anti-starvation counter so a long run of loads cannot block ALU writebacks indefinitely.

---
 rtl/wb_port_scheduler_if.sv | 27 ++
 rtl/wb_port_scheduler.sv | 78 +++++++
 tb/tb_wb_port_scheduler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/wb_port_scheduler_if.sv
// wb_port_scheduler_if: writeback request and issue bundle between the pipeline and wb_port_scheduler.
interface wb_port_scheduler_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_AW-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              MemtoReg;
    logic [DATA_W-1:0] ReadData;
    logic [DATA_W-1:0] ALUresult;
    logic [REG_AW-1:0] WriteReg;
    logic              RegWrite;
    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready, MemtoReg, ReadData, ALUresult, WriteReg, RegWrite
    );
    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready, MemtoReg, ReadData, ALUresult, WriteReg, RegWrite
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler: shares the register-file write port between FIFO-buffered ALU results and priority loads.
// Define WB_BYPASS_EN to let an ALU request skip an empty FIFO when no load competes.
module wb_port_scheduler #(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input logic clk,
    input logic reset,
    wb_port_scheduler_if.slave wb
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [DATA_W-1:0] fifoData [DEPTH];
    logic [REG_AW-1:0] fifoReg [DEPTH];
    logic [PW-1:0]     rdPtr, wrPtr;
    logic [CW-1:0]     count;
    logic [SW-1:0]     starveCnt;
    logic              nonEmpty, forceAlu, issueMem, pop, push, bypass;
    always_comb begin
        nonEmpty     = count != '0;
        forceAlu     = starveCnt == SW'(STARVE_MAX) && nonEmpty;
        issueMem     = wb.mem_valid && !forceAlu;
        pop          = forceAlu || (!wb.mem_valid && nonEmpty);
`ifdef WB_BYPASS_EN
        bypass       = !nonEmpty && !wb.mem_valid && wb.alu_valid;
`else
        bypass       = 1'b0;
`endif
        wb.alu_ready = !reset && count != CW'(DEPTH);
        wb.mem_ready = !reset && !forceAlu;
        push         = wb.alu_valid && wb.alu_ready && !bypass;
    end
    always_ff @(posedge clk)
        if (push) begin
            fifoData[wrPtr] <= wb.alu_data;
            fifoReg[wrPtr]  <= wb.alu_reg;
        end
    // starveCnt only counts loads that overtake a waiting ALU entry
    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr        <= '0;
            wrPtr        <= '0;
            count        <= '0;
            starveCnt    <= '0;
            wb.MemtoReg  <= 1'b0;
            wb.ReadData  <= '0;
            wb.ALUresult <= '0;
            wb.WriteReg  <= '0;
            wb.RegWrite  <= 1'b0;
        end else begin
            rdPtr       <= rdPtr + PW'(pop);
            wrPtr       <= wrPtr + PW'(push);
            count       <= count + CW'(push) - CW'(pop);
            starveCnt   <= (!nonEmpty || pop) ? '0 :
                           (issueMem && starveCnt != SW'(STARVE_MAX)) ? starveCnt + 1'b1 : starveCnt;
            wb.RegWrite <= 1'b0;
            if (issueMem) begin
                wb.MemtoReg <= 1'b1;
                wb.ReadData <= wb.mem_data;
                wb.WriteReg <= wb.mem_reg;
                wb.RegWrite <= |wb.mem_reg;
            end else if (pop) begin
                wb.MemtoReg  <= 1'b0;
                wb.ALUresult <= fifoData[rdPtr];
                wb.WriteReg  <= fifoReg[rdPtr];
                wb.RegWrite  <= |fifoReg[rdPtr];
            end else if (bypass) begin
                wb.MemtoReg  <= 1'b0;
                wb.ALUresult <= wb.alu_data;
                wb.WriteReg  <= wb.alu_reg;
                wb.RegWrite  <= |wb.alu_reg;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_scheduler.sv
// tb_wb_port_scheduler: directed scoreboard bench; expected writebacks are queued with the cycle they must appear in.
module tb_wb_port_scheduler;
`ifdef WB_BYPASS_EN
    localparam int AluLat = 1;
`else
    localparam int AluLat = 2;
`endif
    typedef struct {
        int          cyc;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] d;
        logic        rw;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   nAssert = 0;
    int   nFail = 0;
    exp_t q[$];
    wb_port_scheduler_if #(.DATA_W(32), .REG_AW(5)) bus();
    wb_port_scheduler #(.DATA_W(32), .REG_AW(5), .DEPTH(4), .STARVE_MAX(3)) dut (
        .clk(clk),
        .reset(reset),
        .wb(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        assert (got === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic void expWb(input int c, input logic m, input logic [4:0] r, input logic [31:0] d);
        exp_t e;
        e.cyc = c;
        e.m2r = m;
        e.wr  = r;
        e.d   = d;
        e.rw  = r != 5'd0;
        q.push_back(e);
    endfunction
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (q.size() != 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("MemtoReg", {31'd0, bus.MemtoReg}, {31'd0, e.m2r});
            chk("WriteReg", {27'd0, bus.WriteReg}, {27'd0, e.wr});
            chk("RegWrite", {31'd0, bus.RegWrite}, {31'd0, e.rw});
            chk(e.m2r ? "ReadData" : "ALUresult", e.m2r ? bus.ReadData : bus.ALUresult, e.d);
        end else begin
            chk("idle RegWrite", {31'd0, bus.RegWrite}, 32'd0);
        end
    endtask
    initial begin
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
        // reset and idle state
        tick();
        tick();
        chk("alu_ready in reset", {31'd0, bus.alu_ready}, 32'd0);
        chk("mem_ready in reset", {31'd0, bus.mem_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("reset MemtoReg", {31'd0, bus.MemtoReg}, 32'd0);
        chk("reset WriteReg", {27'd0, bus.WriteReg}, 32'd0);
        chk("reset ReadData", bus.ReadData, 32'd0);
        chk("reset ALUresult", bus.ALUresult, 32'd0);
        chk("idle alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        chk("idle mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        tick();
        // single load
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd8;
        bus.mem_data  = 32'h99;
        expWb(cyc + 1, 1'b1, 5'd8, 32'h99);
        tick();
        bus.mem_valid = 1'b0;
        tick();
        // single ALU result
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd3;
        bus.alu_data  = 32'd146;
        expWb(cyc + AluLat, 1'b0, 5'd3, 32'd146);
        tick();
        bus.alu_valid = 1'b0;
        tick();
        tick();
        // simultaneous load and ALU: load first
        bus.mem_valid = 1'b1;
        bus.mem_reg   = 5'd4;
        bus.mem_data  = 32'd123;
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd5;
        bus.alu_data  = 32'd9431;
        expWb(cyc + 1, 1'b1, 5'd4, 32'd123);
        expWb(cyc + 2, 1'b0, 5'd5, 32'd9431);
        tick();
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        tick();
        tick();
        // starvation: one queued ALU entry against a continuous load stream
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 5'd6;
        bus.alu_data  = 32'h66;
        bus.mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("stream mem_ready", {31'd0, bus.mem_ready}, 32'd1);
            bus.mem_reg  = 5'(10 + i);
            bus.mem_data = 32'h1000 + i;
            expWb(cyc + 1, 1'b1, 5'(10 + i), 32'h1000 + i);
            tick();
            bus.alu_valid = 1'b0;
        end
        chk("forced mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        bus.mem_reg  = 5'd14;
        bus.mem_data = 32'h1004;
        expWb(cyc + 1, 1'b0, 5'd6, 32'h66);
        tick();
        chk("resumed mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        expWb(cyc + 1, 1'b1, 5'd14, 32'h1004);
        tick();
        bus.mem_valid = 1'b0;
        tick();
        // fill the FIFO under load pressure, first entry targets register 0
        bus.alu_valid = 1'b1;
        bus.mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("fill alu_ready", {31'd0, bus.alu_ready}, 32'd1);
            bus.alu_reg  = 5'(i);
            bus.alu_data = 32'hA0 + i;
            bus.mem_reg  = 5'(20 + i);
            bus.mem_data = 32'h2000 + i;
            expWb(cyc + 1, 1'b1, 5'(20 + i), 32'h2000 + i);
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        chk("full alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("full mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        for (int i = 0; i < 4; i++) expWb(cyc + 1 + i, 1'b0, 5'(i), 32'hA0 + i);
        tick();
        chk("drain alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        // reset mid-operation discards queued entries
        bus.alu_valid = 1'b1;
        bus.mem_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.alu_reg  = 5'(7 + i);
            bus.alu_data = 32'hB0 + i;
            bus.mem_reg  = 5'(25 + i);
            bus.mem_data = 32'h3000 + i;
            expWb(cyc + 1, 1'b1, 5'(25 + i), 32'h3000 + i);
            tick();
        end
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid reset WriteReg", {27'd0, bus.WriteReg}, 32'd0);
        chk("mid reset ReadData", bus.ReadData, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("queue drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
